// File: rtl/hazard_tracker_pkg.sv
// Shared definitions for the operand-forwarding producer and the forwarding selector.
// Result-source codes, the "operand not read" Tuse marker and the result-source-to-Tnew mapping.
package hazard_tracker_pkg;

    typedef enum logic [1:0] {
        NW  = 2'b00,
        ALU = 2'b01,
        DM  = 2'b10,
        PC  = 2'b11
    } res_t;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Cycles, counted from entry to E, until the result can be forwarded.
    function automatic logic [1:0] res_to_tnew(input logic [1:0] res);
        logic [1:0] tnew;
        tnew = 2'd0;
        case (res)
            ALU:     tnew = 2'd1;
            DM:      tnew = 2'd2;
            default: tnew = 2'd0;
        endcase
        return tnew;
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Load/decrement occupancy counter for the multi-cycle mult/div unit.
// Busy covers the issue cycle in E plus the programmed number of follow-on cycles.
module md_busy_ctr #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (start) begin
            count_next = div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (count_reg != '0) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign busy = start || (count_reg != '0);

endmodule

// File: rtl/hazard_tracker.sv
// Producer side of operand forwarding: carries a3/res/Tnew down E, M, W and
// raises the D-stage stall for uncoverable register hazards or a busy mult/div unit.
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] a1_d,
    input  logic [4:0] a2_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] a3_d,
    input  logic [1:0] res_d,
    input  logic       md_start_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    output logic [4:0] a3_e,
    output logic [4:0] a3_m,
    output logic [4:0] a3_w,
    output logic [1:0] res_e,
    output logic [1:0] res_m,
    output logic [1:0] res_w,
    output logic [1:0] tnew_e,
    output logic [1:0] tnew_m,
    output logic       md_busy,
    output logic       stall
);

    logic       md_start_e;
    logic       md_div_e;
    logic [4:0] src_a    [2];
    logic [1:0] src_tuse [2];
    logic [1:0] hazard_src;
    logic       hazard_md;

    assign src_a[0]    = a1_d;
    assign src_a[1]    = a2_d;
    assign src_tuse[0] = tuse_rs_d;
    assign src_tuse[1] = tuse_rt_d;

    // The youngest matching producer (E) decides; M is consulted only when E misses.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic hit_e;
        logic hit_m;
        assign hit_e = (src_a[gi] == a3_e);
        assign hit_m = (src_a[gi] == a3_m);
        assign hazard_src[gi] = (src_a[gi] != 5'd0) && (src_tuse[gi] != TUSE_NONE) &&
                                (hit_e ? (tnew_e > src_tuse[gi])
                                       : (hit_m && (tnew_m > src_tuse[gi])));
    end

    assign hazard_md = md_use_d && md_busy;
    assign stall     = (|hazard_src) || hazard_md;

    always_ff @(posedge clk) begin
        if (reset) begin
            a3_e       <= 5'd0;
            res_e      <= 2'd0;
            tnew_e     <= 2'd0;
            md_start_e <= 1'b0;
            md_div_e   <= 1'b0;
            a3_m       <= 5'd0;
            res_m      <= 2'd0;
            tnew_m     <= 2'd0;
            a3_w       <= 5'd0;
            res_w      <= 2'd0;
        end else begin
            if (stall) begin
                a3_e       <= 5'd0;
                res_e      <= 2'd0;
                tnew_e     <= 2'd0;
                md_start_e <= 1'b0;
                md_div_e   <= 1'b0;
            end else begin
                a3_e       <= a3_d;
                res_e      <= res_d;
                tnew_e     <= res_to_tnew(res_d);
                md_start_e <= md_start_d;
                md_div_e   <= md_div_d;
            end
            a3_m   <= a3_e;
            res_m  <= res_e;
            tnew_m <= (tnew_e != 2'd0) ? (tnew_e - 2'd1) : 2'd0;
            a3_w   <= a3_m;
            res_w  <= res_m;
        end
    end

    md_busy_ctr #(
        .MULT_CYC(MULT_CYC),
        .DIV_CYC (DIV_CYC)
    ) u_md_busy_ctr (
        .clk  (clk),
        .reset(reset),
        .start(md_start_e),
        .div  (md_div_e),
        .busy (md_busy)
    );

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// instruction streams checked every cycle against a ready-time based pipeline model.
module tb_hazard_tracker;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] a1_d = '0, a2_d = '0, a3_d = '0;
    logic [1:0] tuse_rs_d = 2'd3, tuse_rt_d = 2'd3, res_d = '0;
    logic       md_start_d = 1'b0, md_div_d = 1'b0, md_use_d = 1'b0;
    logic [4:0] a3_e, a3_m, a3_w;
    logic [1:0] res_e, res_m, res_w, tnew_e, tnew_m;
    logic       md_busy, stall;

    always #5 clk = ~clk;

    hazard_tracker #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .a1_d(a1_d), .a2_d(a2_d),
        .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .a3_d(a3_d), .res_d(res_d),
        .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
        .a3_e(a3_e), .a3_m(a3_m), .a3_w(a3_w), .res_e(res_e), .res_m(res_m), .res_w(res_w),
        .tnew_e(tnew_e), .tnew_m(tnew_m), .md_busy(md_busy), .stall(stall)
    );

    // Model: each in-flight instruction remembers the absolute cycle its result is ready.
    typedef struct {
        logic [4:0] a3;
        logic [1:0] res;
        int         ready;
    } slot_t;

    slot_t me, mm, mw;
    int    now;
    int    md_end;
    int    vectors;
    int    miscompares;

    function automatic int result_latency(input logic [1:0] res);
        return (res == 2'b10) ? 2 : (res == 2'b01) ? 1 : 0;
    endfunction

    function automatic int remaining(input slot_t s, input int t);
        return (s.ready > t) ? s.ready - t : 0;
    endfunction

    function automatic logic model_busy();
        return now <= md_end;
    endfunction

    function automatic logic src_hazard(input logic [4:0] a, input logic [1:0] tuse);
        if (a == 5'd0 || tuse == 2'd3) return 1'b0;
        if (a == me.a3) return remaining(me, now) > int'(tuse);
        if (a == mm.a3) return remaining(mm, now) > int'(tuse);
        return 1'b0;
    endfunction

    function automatic logic model_stall();
        return src_hazard(a1_d, tuse_rs_d) || src_hazard(a2_d, tuse_rt_d) ||
               (md_use_d && model_busy());
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, now);
        end
    endtask

    task automatic check_model();
        cmp("a3_e", 8'(a3_e), 8'(me.a3));
        cmp("a3_m", 8'(a3_m), 8'(mm.a3));
        cmp("a3_w", 8'(a3_w), 8'(mw.a3));
        cmp("res_e", 8'(res_e), 8'(me.res));
        cmp("res_m", 8'(res_m), 8'(mm.res));
        cmp("res_w", 8'(res_w), 8'(mw.res));
        cmp("tnew_e", 8'(tnew_e), 8'(remaining(me, now)));
        cmp("tnew_m", 8'(tnew_m), 8'(remaining(mm, now)));
        cmp("md_busy", 8'(md_busy), 8'(model_busy()));
        cmp("stall", 8'(stall), 8'(model_stall()));
    endtask

    task automatic drive(input logic [4:0] a1, input logic [1:0] trs,
                         input logic [4:0] a2, input logic [1:0] trt,
                         input logic [4:0] a3, input logic [1:0] res,
                         input logic ms, input logic md, input logic mu);
        a1_d = a1; tuse_rs_d = trs; a2_d = a2; tuse_rt_d = trt;
        a3_d = a3; res_d = res; md_start_d = ms; md_div_d = md; md_use_d = mu;
        #1;
        check_model();
    endtask

    task automatic tick();
        logic st;
        st = model_stall();
        if (reset) begin
            me = '{5'd0, 2'd0, 0};
            mm = '{5'd0, 2'd0, 0};
            mw = '{5'd0, 2'd0, 0};
            md_end = -1;
            now++;
        end else begin
            mw = mm;
            mm = me;
            now++;
            if (st) begin
                me = '{5'd0, 2'd0, now};
            end else begin
                me = '{a3_d, res_d, now + result_latency(res_d)};
                if (md_start_d) md_end = now + (md_div_d ? DIV_CYC : MULT_CYC);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic idle();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        @(posedge clk);
        @(negedge clk);
        me = '{5'd0, 2'd0, 0};
        mm = '{5'd0, 2'd0, 0};
        mw = '{5'd0, 2'd0, 0};
        now = 0;
        md_end = -1;
        reset = 1'b0;

        // Reset state
        idle();
        cmp("rst_a3_e", 8'(a3_e), 8'd0);
        cmp("rst_md_busy", 8'(md_busy), 8'd0);
        cmp("rst_stall", 8'(stall), 8'd0);
        tick();

        // lw $5 then add reading $5 at tuse 1: one stall cycle
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd5, 2'd1, 5'd6, 2'd1, 5'd3, 2'b01, 1'b0, 1'b0, 1'b0);
        cmp("lw_add_tnew_e", 8'(tnew_e), 8'd2);
        cmp("lw_add_stall1", 8'(stall), 8'd1);
        tick();
        drive(5'd5, 2'd1, 5'd6, 2'd1, 5'd3, 2'b01, 1'b0, 1'b0, 1'b0);
        cmp("lw_add_bubble", 8'(a3_e), 8'd0);
        cmp("lw_add_a3_m", 8'(a3_m), 8'd5);
        cmp("lw_add_tnew_m", 8'(tnew_m), 8'd1);
        cmp("lw_add_stall2", 8'(stall), 8'd0);
        tick();

        // lw $5 then beq reading $5 at tuse 0: two stall cycles
        do_reset();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(5'd5, 2'd0, 5'd0, 2'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
            cmp("lw_beq_stall", 8'(stall), 8'd1);
            tick();
        end
        drive(5'd5, 2'd0, 5'd0, 2'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        cmp("lw_beq_release", 8'(stall), 8'd0);
        cmp("lw_beq_a3_w", 8'(a3_w), 8'd5);
        tick();

        // addu $7 then sw reading $7 as rt at tuse 2: no stall
        do_reset();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 2'd3, 5'd7, 2'd2, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        cmp("addu_sw_stall", 8'(stall), 8'd0);
        tick();
        idle();
        cmp("addu_sw_a3_m", 8'(a3_m), 8'd7);
        cmp("addu_sw_res_m", 8'(res_m), 8'd1);
        tick();

        // $0 reads against a load with no destination
        do_reset();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        cmp("zero_res_e", 8'(res_e), 8'd2);
        cmp("zero_stall", 8'(stall), 8'd0);
        tick();

        // div then mflo: held for 11 cycles
        do_reset();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'b00, 1'b1, 1'b1, 1'b1);
        tick();
        for (int i = 0; i <= DIV_CYC; i++) begin
            drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'b01, 1'b0, 1'b0, 1'b1);
            cmp("div_busy", 8'(md_busy), 8'd1);
            cmp("div_stall", 8'(stall), 8'd1);
            tick();
        end
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'b01, 1'b0, 1'b0, 1'b1);
        cmp("div_done_busy", 8'(md_busy), 8'd0);
        cmp("div_done_stall", 8'(stall), 8'd0);
        tick();

        // Reset while stalled with the counter at 6
        do_reset();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'b00, 1'b1, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'b01, 1'b0, 1'b0, 1'b1);
            tick();
        end
        reset = 1'b1;
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'b01, 1'b0, 1'b0, 1'b1);
        cmp("pre_reset_stall", 8'(stall), 8'd1);
        tick();
        reset = 1'b0;
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'b01, 1'b0, 1'b0, 1'b1);
        cmp("post_reset_busy", 8'(md_busy), 8'd0);
        cmp("post_reset_stall", 8'(stall), 8'd0);
        cmp("post_reset_a3_e", 8'(a3_e), 8'd0);
        tick();

        // Random instruction stream over a small register window
        for (int n = 0; n < 3000; n++) begin
            logic ms;
            reset = ($urandom_range(0, 199) == 0);
            ms = ($urandom_range(0, 9) == 0);
            drive(5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  ms, 1'($urandom_range(0, 1)),
                  ms | ($urandom_range(0, 3) == 0));
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
